// File: rtl/bmp_scan_ctrl_pkg.sv
// bmp_scan_pkg: shared state type and sizes for the bitmap scan sequencer
package bmp_scan_pkg;
  localparam int NCOLS_DEF = 24;
  localparam int NROWS_DEF = 64;
  localparam int TMO_DEF = 15;
  localparam int IDX_W = 6;
  localparam int TMO_W = 8;
  typedef enum logic [3:0] {IDLE, LOAD, CREQ, CWAIT, CALU, RREQ, RWAIT, RALU, DONE, ERR} state_t;
endpackage

// File: rtl/bmp_scan_ctrl_if.sv
// bmp_scan_ctrl_if: slice-register and ALU handshake bundle of the scan sequencer
interface bmp_scan_ctrl_if;
  logic bmp_wren, nextcol, nextrow, colready, rowready, alu_valid, alu_ready, alu_sel;
  logic [bmp_scan_pkg::IDX_W-1:0] idx;
  modport master (output bmp_wren, nextcol, nextrow, alu_valid, alu_sel, idx, input colready, rowready, alu_ready);
  modport slave (input bmp_wren, nextcol, nextrow, alu_valid, alu_sel, idx, output colready, rowready, alu_ready);
endinterface

// File: rtl/bmp_scan_ctrl_tmo.sv
// bmp_scan_tmo: clearable saturating timeout counter, expired flags the counting cycle that reaches TMO
module bmp_scan_tmo import bmp_scan_pkg::*; #(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != TMO_W'(TMO)) ? cnt + TMO_W'(1) : cnt;
  always_comb expired = en && cnt >= TMO_W'(TMO - 1);
endmodule

// File: rtl/bmp_scan_ctrl.sv
// bmp_scan_ctrl: loads a bitmap, then hands every column and row slice to the compare ALU
module bmp_scan_ctrl import bmp_scan_pkg::*; #(
  parameter int NCOLS = NCOLS_DEF,
  parameter int NROWS = NROWS_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  bmp_scan_ctrl_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state;
  logic tmo_clr, tmo_en, expired;
  always_comb tmo_clr = abort || state == CREQ || state == RREQ;
  always_comb tmo_en = !abort && ((state == CWAIT && !bus.colready) || (state == RWAIT && !bus.rowready));
  bmp_scan_tmo #(.TMO(TMO)) u_tmo (.clk(clk), .rst_n(rst_n), .clr(tmo_clr), .en(tmo_en), .expired(expired));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.bmp_wren <= 1'b0;
      bus.nextcol <= 1'b0;
      bus.nextrow <= 1'b0;
      bus.alu_valid <= 1'b0;
      bus.alu_sel <= 1'b0;
      bus.idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      bus.bmp_wren <= 1'b0;
      bus.nextcol <= 1'b0;
      bus.nextrow <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        bus.alu_valid <= 1'b0;
        bus.alu_sel <= 1'b0;
        bus.idx <= '0;
        busy <= 1'b0;
        err <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: if (start) begin
            state <= LOAD;
            bus.bmp_wren <= 1'b1;
            bus.idx <= '0;
            bus.alu_sel <= 1'b0;
            busy <= 1'b1;
            err <= 1'b0;
          end
          LOAD: begin
            state <= CREQ;
            bus.nextcol <= 1'b1;
          end
          CREQ: state <= CWAIT;
          CWAIT: if (bus.colready) begin
            state <= CALU;
            bus.alu_valid <= 1'b1;
          end else if (expired) begin
            state <= ERR;
            busy <= 1'b0;
            err <= 1'b1;
          end
          CALU: if (bus.alu_ready) begin
            bus.alu_valid <= 1'b0;
            if (bus.idx == IDX_W'(NCOLS - 1)) begin
              state <= RREQ;
              bus.idx <= '0;
              bus.alu_sel <= 1'b1;
              bus.nextrow <= 1'b1;
            end else begin
              state <= CREQ;
              bus.idx <= bus.idx + IDX_W'(1);
              bus.nextcol <= 1'b1;
            end
          end
          RREQ: state <= RWAIT;
          RWAIT: if (bus.rowready) begin
            state <= RALU;
            bus.alu_valid <= 1'b1;
          end else if (expired) begin
            state <= ERR;
            busy <= 1'b0;
            err <= 1'b1;
          end
          RALU: if (bus.alu_ready) begin
            bus.alu_valid <= 1'b0;
            if (bus.idx == IDX_W'(NROWS - 1)) begin
              state <= DONE;
              bus.idx <= '0;
              bus.alu_sel <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= RREQ;
              bus.idx <= bus.idx + IDX_W'(1);
              bus.nextrow <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// tb_bmp_scan_ctrl: randomized scans checked against slice-plan timing and ordering rules
module tb_bmp_scan_ctrl;
  localparam int NC = 24;
  localparam int NR = 64;
  localparam int TMO = 15;
  localparam int NS = NC + NR;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, err;
  bmp_scan_ctrl_if bus();
  bmp_scan_ctrl #(.NCOLS(NC), .NROWS(NR), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cd[NS+1];
  int ad[NS+1];
  int cyc = 0;
  int slice, hold, pend, pokes;
  bit prow, pv, pr, psel, ralu_poke;
  logic [5:0] pidx;
  int n_wren, n_col, n_row, n_done, load_cyc, done_cyc, err_cyc, stab_err, busy_bad;
  int hs_idx[$];
  int hs_cyc[$];
  int req_cyc[$];
  bit hs_sel[$];
  // cycle offset from LOAD to the request of slice j: LOAD then cd+ad+2 cycles per slice
  function automatic int slice_off(int j);
    int s = 1;
    for (int i = 0; i < j; i++) s += cd[i] + ad[i] + 2;
    return s;
  endfunction
  function automatic bit seq_bad();
    if (hs_idx.size() != NS) return 1'b1;
    for (int k = 0; k < NS; k++)
      if (hs_idx[k] != (k < NC ? k : k - NC) || hs_sel[k] != (k >= NC)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic set_plan(input int cmin, input int cmax, input int amax);
    for (int i = 0; i <= NS; i++) begin
      cd[i] = int'($urandom_range(cmax, cmin));
      ad[i] = int'($urandom_range(amax, 0));
    end
  endtask
  task automatic clear_obs();
    n_wren = 0; n_col = 0; n_row = 0; n_done = 0; pokes = 0;
    load_cyc = -1; done_cyc = -1; err_cyc = -1; stab_err = 0; busy_bad = 0;
    slice = 0; hold = 0; pend = 0; prow = 0; pv = 0; pr = 0; psel = 0; pidx = '0;
    hs_idx.delete(); hs_cyc.delete(); req_cyc.delete(); hs_sel.delete();
    bus.colready = 1'b0; bus.rowready = 1'b0; bus.alu_ready = 1'b0;
  endtask
  // one clock: observe outputs, then act as slice register and ALU for the coming edge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.bmp_wren) begin n_wren++; load_cyc = cyc; end
    if (bus.nextcol || bus.nextrow) req_cyc.push_back(cyc);
    if (bus.nextcol) n_col++;
    if (bus.nextrow) n_row++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (err && err_cyc < 0) err_cyc = cyc;
    if (bus.alu_valid && !busy) busy_bad++;
    if (pv && !pr && !(bus.alu_valid && bus.idx == pidx && bus.alu_sel == psel)) stab_err++;
    if (pend > 0) begin
      pend--;
      bus.colready = pend == 0 && !prow;
      bus.rowready = pend == 0 && prow;
    end else begin
      bus.colready = 1'b0;
      bus.rowready = 1'b0;
    end
    if (bus.nextcol || bus.nextrow) begin pend = cd[slice]; prow = bus.nextrow; end
    bus.alu_ready = 1'b0;
    if (bus.alu_valid) begin
      bus.alu_ready = hold == ad[slice];
      hold++;
      if (bus.alu_ready) begin
        hs_idx.push_back(int'(bus.idx)); hs_sel.push_back(bus.alu_sel); hs_cyc.push_back(cyc);
        hold = 0; slice++;
      end
    end
    if (ralu_poke) begin
      start = bus.alu_valid && bus.alu_sel && bus.idx == 6'd10;
      if (start) pokes++;
    end
    pv = bus.alu_valid; pr = bus.alu_ready; pidx = bus.idx; psel = bus.alu_sel;
  endtask
  task automatic begin_scan();
    clear_obs();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_end(input string tag);
    for (int i = 0; i < 3000 && n_done == 0 && err_cyc < 0; i++) step();
    checks++;
    if (n_done == 0 && err_cyc < 0) begin errors++; $display("FAIL %s_end no done/err within budget", tag); end
  endtask
  task automatic test_reset();
    clear_obs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.bmp_wren, bus.nextcol, bus.nextrow, bus.alu_valid, bus.alu_sel, bus.idx, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs exp all 0");
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || n_wren != 0) begin errors++; $display("FAIL reset_idle busy %b wren %0d exp 0 0", busy, n_wren); end
    set_plan(1, 1, 0);
    begin_scan();
    for (int i = 0; i < 100 && !(bus.alu_valid && !bus.alu_sel && bus.idx == 6'd5); i++) step();
    checks++;
    if (!(bus.alu_valid && !bus.alu_sel && bus.idx == 6'd5)) begin errors++; $display("FAIL reset_reach_col5 idx %0d valid %b", bus.idx, bus.alu_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bmp_wren, bus.nextcol, bus.nextrow, bus.alu_valid, bus.alu_sel, bus.idx, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_async got valid %b idx %0d busy %b exp 0", bus.alu_valid, bus.idx, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (6) step();
    checks++;
    if (busy !== 1'b0 || bus.idx !== 6'd0 || n_wren != 0 || n_col != 0) begin
      errors++; $display("FAIL reset_after busy %b idx %0d wren %0d col %0d exp 0", busy, bus.idx, n_wren, n_col);
    end
  endtask
  task automatic test_nominal();
    set_plan(1, 1, 0);
    begin_scan();
    wait_end("nominal");
    checks++;
    if (n_col != NC || n_row != NR) begin errors++; $display("FAIL nominal_pulses col %0d row %0d exp %0d %0d", n_col, n_row, NC, NR); end
    checks++;
    if (seq_bad()) begin errors++; $display("FAIL nominal_idx_seq got %0d handshakes exp %0d in order", hs_idx.size(), NS); end
    checks++;
    if (done_cyc - load_cyc != 1 + 3 * NS) begin errors++; $display("FAIL nominal_done_cyc got %0d exp %0d", done_cyc - load_cyc, 1 + 3 * NS); end
    checks++;
    if (n_done != 1 || err_cyc >= 0 || busy !== 1'b0 || busy_bad != 0) begin
      errors++; $display("FAIL nominal_status done %0d errcyc %0d busy %b busybad %0d", n_done, err_cyc, busy, busy_bad);
    end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_pulse got %b exp 0", done); end
  endtask
  task automatic test_backpressure();
    set_plan(1, 1, 0);
    ad[7] = 4;
    begin_scan();
    wait_end("backpressure");
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stab_err); end
    checks++;
    if (hs_cyc.size() < 9 || req_cyc.size() < 9) begin
      errors++; $display("FAIL bp_count got %0d handshakes", hs_cyc.size());
    end else if (hs_cyc[7] - req_cyc[7] != 6 || req_cyc[8] != hs_cyc[7] + 1) begin
      errors++; $display("FAIL bp_timing hs %0d req7 %0d req8 %0d exp hs=req7+6 req8=hs+1", hs_cyc[7], req_cyc[7], req_cyc[8]);
    end
    checks++;
    if (done_cyc - load_cyc != slice_off(NS) || seq_bad()) begin
      errors++; $display("FAIL bp_done_cyc got %0d exp %0d", done_cyc - load_cyc, slice_off(NS));
    end
  endtask
  task automatic test_timeout();
    set_plan(1, 1, 0);
    cd[3] = 1000;
    begin_scan();
    wait_end("timeout");
    checks++;
    if (err_cyc - load_cyc != slice_off(3) + 1 + TMO) begin
      errors++; $display("FAIL tmo_err_cyc got %0d exp %0d", err_cyc - load_cyc, slice_off(3) + 1 + TMO);
    end
    checks++;
    if (busy !== 1'b0 || n_done != 0 || n_col != 4) begin errors++; $display("FAIL tmo_status busy %b done %0d col %0d exp 0 0 4", busy, n_done, n_col); end
    repeat (3) step();
    checks++;
    if (err !== 1'b1 || n_col != 4) begin errors++; $display("FAIL tmo_hold err %b col %0d exp 1 4", err, n_col); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (bus.bmp_wren !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_restart wren %b err %b busy %b exp 1 0 1", bus.bmp_wren, err, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.idx !== 6'd0) begin errors++; $display("FAIL tmo_abort busy %b idx %0d exp 0 0", busy, bus.idx); end
  endtask
  task automatic test_tmo_boundary();
    set_plan(1, 1, 0);
    cd[3] = TMO;
    cd[NC + 5] = TMO;
    begin_scan();
    wait_end("boundary");
    checks++;
    if (err_cyc >= 0 || n_done != 1) begin errors++; $display("FAIL boundary_no_err errcyc %0d done %0d exp -1 1", err_cyc, n_done); end
    checks++;
    if (done_cyc - load_cyc != slice_off(NS)) begin errors++; $display("FAIL boundary_done_cyc got %0d exp %0d", done_cyc - load_cyc, slice_off(NS)); end
  endtask
  task automatic test_start_ignored();
    set_plan(1, 1, 0);
    ralu_poke = 1'b1;
    begin_scan();
    wait_end("start_ign");
    ralu_poke = 1'b0;
    start = 1'b0;
    checks++;
    if (pokes == 0 || n_wren != 1 || n_done != 1) begin
      errors++; $display("FAIL start_ign pokes %0d wren %0d done %0d exp >0 1 1", pokes, n_wren, n_done);
    end
    checks++;
    if (done_cyc - load_cyc != slice_off(NS)) begin errors++; $display("FAIL start_ign_cyc got %0d exp %0d", done_cyc - load_cyc, slice_off(NS)); end
  endtask
  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      set_plan(1, TMO, 3);
      begin_scan();
      wait_end("random");
      checks++;
      if (done_cyc - load_cyc != slice_off(NS) || err_cyc >= 0) begin
        errors++; $display("FAIL random_done_cyc it %0d got %0d exp %0d", it, done_cyc - load_cyc, slice_off(NS));
      end
      checks++;
      if (seq_bad() || n_col != NC || n_row != NR || stab_err != 0) begin
        errors++; $display("FAIL random_seq it %0d hs %0d col %0d row %0d unstable %0d", it, hs_idx.size(), n_col, n_row, stab_err);
      end
    end
  endtask
  task automatic test_abort();
    set_plan(1, 1, 0);
    cd[NC + 40] = 6;
    begin_scan();
    for (int i = 0; i < 1000 && n_row < 41; i++) step();
    step();
    checks++;
    if (n_row != 41 || bus.alu_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_reach row %0d valid %b busy %b exp 41 0 1", n_row, bus.alu_valid, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.idx !== 6'd0 || bus.alu_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy %b idx %0d valid %b done %b exp 0", busy, bus.idx, bus.alu_valid, done);
    end
    repeat (20) step();
    checks++;
    if (n_row != 41 || n_done != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet row %0d done %0d exp 41 0", n_row, n_done); end
  endtask
  initial begin
    ralu_poke = 1'b0;
    clear_obs();
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_tmo_boundary();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bmp_scan_ctrl.md
Name: bmp_scan_ctrl

Overview:
- Sequencer for the 24x64 bitmap slice register and the compare ALU.
- On start, it loads a bitmap into the slice register, then steps through all 24 column slices and then all 64 row slices.
- Each slice is handed to the ALU with a valid/ready handshake.
- It reports done, or reports an error if a slice-ready acknowledge times out.

Parameters:
- NCOLS, 24, number of column slices per bitmap
- NROWS, 64, number of row slices per bitmap
- TMO, 15, max cycles to wait for colready/rowready before error (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE or ERR
- abort  in  1  synchronous abort; returns to IDLE from any state
- bmp_wren  out  1  one-cycle load strobe to slice register
- nextcol  out  1  one-cycle request for next column slice
- nextrow  out  1  one-cycle request for next row slice
- colready  in  1  slice register column slice valid
- rowready  in  1  slice register row slice valid
- alu_valid  out  1  slice presented to ALU
- alu_ready  in  1  ALU accepts slice
- alu_sel  out  1  0 = column slice, 1 = row slice
- idx  out  6  index of current slice (column 0..23 or row 0..63)
- busy  out  1  high in every state except IDLE, DONE and ERR
- done  out  1  one-cycle pulse at scan completion
- err  out  1  timeout flag, held until cleared

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; idx, timeout counter and slice counters cleared.
- States: IDLE, LOAD, CREQ, CWAIT, CALU, RREQ, RWAIT, RALU, DONE, ERR. All outputs registered (Moore).
- IDLE: start=1 -> LOAD next cycle.
- LOAD: bmp_wren=1 for exactly one cycle; idx=0 -> CREQ.
- CREQ: nextcol=1 for one cycle; timeout counter cleared -> CWAIT.
- CWAIT:
  - colready=1 -> CALU.
  - Otherwise the counter increments; when it reaches TMO -> ERR.
  - colready arriving in the same cycle the counter hits TMO wins (-> CALU).
- CALU: alu_valid=1, alu_sel=0, held until alu_ready=1.
  - On handshake, if idx==NCOLS-1 then idx=0 -> RREQ.
  - Else idx+1 -> CREQ.
  - No timeout on alu_ready.
- RREQ, RWAIT, RALU: identical to the column states, using nextrow/rowready and alu_sel=1.
  - Terminal row count is NROWS-1; terminal handshake -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR:
  - err=1 is held.
  - start=1 clears err and -> LOAD.
  - abort=1 clears err and -> IDLE.
- start is ignored while busy; no queuing.
- abort is checked before all other transitions. It forces IDLE next cycle and clears all strobes, alu_valid, idx and the counters. done is not pulsed.
- Throughput: minimum 3 cycles per slice (REQ, WAIT with immediate ready, ALU with immediate alu_ready).
- Minimum scan: 1 + 3*(NCOLS+NROWS) cycles, plus 1 DONE cycle.
- Widths:
  - idx is 6 bits and wraps only via the explicit terminal compare.
  - Timeout counter is 8 bits and saturates at TMO.

Decomposition:
- Package bmp_scan_pkg holds:
  - the state enum type;
  - NCOLS/NROWS defaults;
  - IDX_W=6 and TMO_W=8.
- One natural sub-module: bmp_scan_tmo, a clearable saturating timeout counter with clr, en and expired ports. Instantiated once.

Test Plan:
- Reset mid-scan: assert rst_n low during CALU at idx=5 -> all outputs 0 immediately; after release, state IDLE and busy=0.
- Nominal scan, colready/rowready returned 1 cycle after each request, alu_ready tied 1:
  - exactly 24 nextcol and 64 nextrow pulses;
  - idx sequence 0..23 then 0..63;
  - done pulses once at cycle 1+3*88 after LOAD entry.
- ALU backpressure: alu_ready low for 4 cycles at column 7 -> alu_valid, alu_sel=0 and idx=7 held stable for all 4 cycles; the next nextcol follows the handshake.
- Timeout: colready never returns for column 3 -> err=1 at 15 cycles after CWAIT entry, busy=0. A following start clears err and re-issues bmp_wren.
- Boundaries:
  - colready asserted in the exact cycle the timeout counter reaches TMO -> no err, proceeds to CALU.
  - start pulsed during RALU -> ignored, no second bmp_wren.
- Abort during RWAIT at row 40 -> IDLE next cycle, no done, idx=0, no further nextrow.
